// File: rtl/rx_link_arbiter.sv
// Round-robin arbiter merging N toggle-handshake RX links onto one AXI-Stream master, one burst per grant.
// Define RX_ARB_HEADER_EN to prefix every burst with a {8'hA5, link} header beat.
module rx_link_arbiter #(
    parameter int unsigned N_LINKS      = 4,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned IDLE_TIMEOUT = 100,
    parameter int unsigned MAX_BURST    = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_LINKS-1:0]         RX_REQ,
    input  logic [N_LINKS*DATA_W-1:0]  RX_DATA,
    output logic [N_LINKS-1:0]         RX_ACK,
    output logic [DATA_W-1:0]          M_AXIS_TDATA,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    output logic [1:0]                 M_AXIS_TKEEP,
    output logic                       M_AXIS_TLAST,
    output logic                       BURST_DONE,
    output logic [$clog2(N_LINKS)-1:0] BURST_CH,
    output logic [31:0]                BURST_COUNT,
    output logic                       BUSY
);
    localparam int unsigned CH_W = $clog2(N_LINKS);
    localparam int unsigned IC_W = $clog2(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef RX_ARB_HEADER_EN
        S_HEADER = 2'd1,
`endif
        S_RECV   = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t              state_q;
    logic [N_LINKS-1:0]  req_meta_q;
    logic [N_LINKS-1:0]  req_s_q;
    logic [N_LINKS-1:0]  ack_q;
    logic [CH_W-1:0]     grant_q;
    logic [CH_W-1:0]     last_grant_q;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_valid_q;
    logic [IC_W-1:0]     idle_cnt_q;
    logic [DATA_W-1:0]   tdata_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic                done_q;
    logic [CH_W-1:0]     ch_q;
    logic [31:0]         count_q;

    logic [N_LINKS-1:0]  pending;
    logic                out_free;
    logic [DATA_W-1:0]   rx_word;
    logic [CH_W-1:0]     arb_idx;
    logic [CH_W-1:0]     arb_grant_d;
    logic                flush_due;
    logic                capture;

    assign pending   = req_s_q ^ ack_q;
    assign out_free  = !tvalid_q || M_AXIS_TREADY;
    assign rx_word   = RX_DATA[32'(grant_q) * DATA_W +: DATA_W];
    assign flush_due = hold_valid_q &&
                       (idle_cnt_q == IC_W'(IDLE_TIMEOUT - 1) || count_q == MAX_BURST);
    assign capture   = pending[grant_q] && (!hold_valid_q || out_free) && (count_q < MAX_BURST);

    // Scan from the farthest link back to the nearest so the closest pending link after last_grant wins.
    always_comb begin
        arb_idx     = '0;
        arb_grant_d = last_grant_q;
        for (int unsigned k = N_LINKS; k >= 1; k--) begin
            arb_idx = CH_W'((32'(last_grant_q) + k) % N_LINKS);
            if (pending[arb_idx]) begin
                arb_grant_d = arb_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q   <= '0;
            req_s_q      <= '0;
            ack_q        <= '0;
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(N_LINKS - 1);
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            idle_cnt_q   <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            done_q       <= 1'b0;
            ch_q         <= '0;
            count_q      <= '0;
        end else begin
            req_meta_q <= RX_REQ;
            req_s_q    <= req_meta_q;
            done_q     <= 1'b0;
            if (tvalid_q && M_AXIS_TREADY) begin
                tvalid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (|pending) begin
                        grant_q    <= arb_grant_d;
                        ch_q       <= arb_grant_d;
                        count_q    <= '0;
                        idle_cnt_q <= '0;
`ifdef RX_ARB_HEADER_EN
                        state_q    <= S_HEADER;
`else
                        state_q    <= S_RECV;
`endif
                    end
                end
`ifdef RX_ARB_HEADER_EN
                S_HEADER: begin
                    if (out_free) begin
                        tdata_q  <= DATA_W'({8'hA5, 8'(grant_q)});
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        state_q  <= S_RECV;
                    end
                end
`endif
                S_RECV: begin
                    // The hold register lags by one word so the burst's final word can still get TLAST.
                    if (flush_due) begin
                        state_q <= S_FLUSH;
                    end else if (capture) begin
                        if (hold_valid_q) begin
                            tdata_q  <= hold_q;
                            tvalid_q <= 1'b1;
                            tlast_q  <= 1'b0;
                        end
                        hold_q         <= rx_word;
                        hold_valid_q   <= 1'b1;
                        ack_q[grant_q] <= ~ack_q[grant_q];
                        count_q        <= count_q + 32'd1;
                        idle_cnt_q     <= '0;
                    end else if (hold_valid_q && !pending[grant_q] &&
                                 idle_cnt_q != IC_W'(IDLE_TIMEOUT - 1)) begin
                        idle_cnt_q <= idle_cnt_q + IC_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        tdata_q      <= hold_q;
                        tvalid_q     <= 1'b1;
                        tlast_q      <= 1'b1;
                        hold_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        last_grant_q <= grant_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RX_ACK        = ack_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TKEEP  = 2'b11;
    assign M_AXIS_TLAST  = tlast_q;
    assign BURST_DONE    = done_q;
    assign BURST_CH      = ch_q;
    assign BURST_COUNT   = count_q;
    assign BUSY          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_link_arbiter.sv
// Directed bench for rx_link_arbiter: dut0 uses default parameters, dut1 a short burst/timeout build.
// Beat expectations include the header beat when RX_ARB_HEADER_EN is defined.
module tb_rx_link_arbiter;
    localparam bit HDR =
`ifdef RX_ARB_HEADER_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req    [2];
    logic [63:0] data   [2];
    logic        tready [2];
    logic [3:0]  ack    [2];
    logic [15:0] tdata  [2];
    logic        tvalid [2];
    logic        tlast  [2];
    logic        done   [2];
    logic        busy   [2];
    logic [1:0]  tkeep  [2];
    logic [1:0]  ch     [2];
    logic [31:0] cnt    [2];

    int vectors = 0;
    int errors  = 0;

    logic [16:0] beats0[$];
    logic [16:0] beats1[$];
    logic [33:0] dones0[$];
    logic [33:0] dones1[$];

    rx_link_arbiter dut0 (
        .clk(clk), .rst_n(rst_n), .RX_REQ(req[0]), .RX_DATA(data[0]), .RX_ACK(ack[0]),
        .M_AXIS_TDATA(tdata[0]), .M_AXIS_TVALID(tvalid[0]), .M_AXIS_TREADY(tready[0]),
        .M_AXIS_TKEEP(tkeep[0]), .M_AXIS_TLAST(tlast[0]), .BURST_DONE(done[0]),
        .BURST_CH(ch[0]), .BURST_COUNT(cnt[0]), .BUSY(busy[0])
    );

    rx_link_arbiter #(.MAX_BURST(4), .IDLE_TIMEOUT(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .RX_REQ(req[1]), .RX_DATA(data[1]), .RX_ACK(ack[1]),
        .M_AXIS_TDATA(tdata[1]), .M_AXIS_TVALID(tvalid[1]), .M_AXIS_TREADY(tready[1]),
        .M_AXIS_TKEEP(tkeep[1]), .M_AXIS_TLAST(tlast[1]), .BURST_DONE(done[1]),
        .BURST_CH(ch[1]), .BURST_COUNT(cnt[1]), .BUSY(busy[1])
    );

    // Inputs only change 1ns after posedge, so the negedge sees exactly what the next edge accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid[0] && tready[0]) beats0.push_back({tlast[0], tdata[0]});
            if (tvalid[1] && tready[1]) beats1.push_back({tlast[1], tdata[1]});
            if (done[0]) dones0.push_back({ch[0], cnt[0]});
            if (done[1]) dones1.push_back({ch[1], cnt[1]});
        end
    end

    function automatic logic [16:0] hdr(input logic [1:0] c);
        return {1'b0, 8'hA5, 6'd0, c};
    endfunction

    task automatic clear_queues();
        beats0.delete(); beats1.delete(); dones0.delete(); dones1.delete();
    endtask

    task automatic wait_ack(input int d, input int l, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            seen = (ack[d][l] === req[d][l]);
        end
        if (!seen) begin
            $display("FAIL ack_timeout dut%0d link%0d: RX_ACK=%b, required bit %0d = %b",
                     d, l, ack[d], l, req[d][l]);
            errors++;
        end
    endtask

    task automatic send(input int d, input int l, input logic [15:0] w);
        data[d][l*16 +: 16] = w;
        req[d][l] = ~req[d][l];
        wait_ack(d, l, 60);
    endtask

    task automatic wait_done(input int d, input int n, input int budget, output int waited);
        waited = 0;
        while (((d == 0) ? dones0.size() : dones1.size()) < n && waited < budget) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= budget) begin
            $display("FAIL done_timeout dut%0d: %0d bursts seen, required %0d", d,
                     (d == 0) ? dones0.size() : dones1.size(), n);
            errors++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req[0] = '0;
        req[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_queues();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req[0] = '0;
        req[1] = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++; if (ack[d] !== 4'b0)     begin $display("FAIL rst_ack dut%0d: got %b, required 0000", d, ack[d]); errors++; end
            vectors++; if (tvalid[d] !== 1'b0)  begin $display("FAIL rst_tvalid dut%0d: got %b, required 0", d, tvalid[d]); errors++; end
            vectors++; if (tlast[d] !== 1'b0)   begin $display("FAIL rst_tlast dut%0d: got %b, required 0", d, tlast[d]); errors++; end
            vectors++; if (tdata[d] !== 16'h0)  begin $display("FAIL rst_tdata dut%0d: got %h, required 0000", d, tdata[d]); errors++; end
            vectors++; if (done[d] !== 1'b0)    begin $display("FAIL rst_done dut%0d: got %b, required 0", d, done[d]); errors++; end
            vectors++; if (ch[d] !== 2'd0)      begin $display("FAIL rst_ch dut%0d: got %0d, required 0", d, ch[d]); errors++; end
            vectors++; if (cnt[d] !== 32'd0)    begin $display("FAIL rst_count dut%0d: got %0d, required 0", d, cnt[d]); errors++; end
            vectors++; if (busy[d] !== 1'b0)    begin $display("FAIL rst_busy dut%0d: got %b, required 0", d, busy[d]); errors++; end
            vectors++; if (tkeep[d] !== 2'b11)  begin $display("FAIL rst_tkeep dut%0d: got %b, required 11", d, tkeep[d]); errors++; end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (busy[0] !== 1'b0 || tvalid[0] !== 1'b0) begin
            $display("FAIL rst_quiet dut0: busy=%b tvalid=%b, required 0 0", busy[0], tvalid[0]); errors++;
        end
        clear_queues();
    endtask

    // T1: three words on link0, burst closed by idle timeout.
    task automatic test_single_burst();
        logic [16:0] exp[$];
        int waited;
        send(0, 0, 16'h0001);
        send(0, 0, 16'h0002);
        send(0, 0, 16'h0003);
        wait_done(0, 1, 200, waited);
        repeat (2) @(posedge clk); #1;
        if (HDR) exp.push_back(hdr(2'd0));
        exp.push_back({1'b0, 16'h0001});
        exp.push_back({1'b0, 16'h0002});
        exp.push_back({1'b1, 16'h0003});
        vectors++; if (beats0.size() != exp.size()) begin $display("FAIL t1_beat_count: got %0d, required %0d", beats0.size(), exp.size()); errors++; end
        for (int i = 0; i < exp.size() && i < beats0.size(); i++) begin
            vectors++; if (beats0[i] !== exp[i]) begin $display("FAIL t1_beat%0d: got %h, required %h", i, beats0[i], exp[i]); errors++; end
        end
        vectors++; if (dones0.size() != 1) begin $display("FAIL t1_done_pulses: got %0d, required 1", dones0.size()); errors++; end
        if (dones0.size() > 0) begin
            vectors++; if (dones0[0] !== {2'd0, 32'd3}) begin $display("FAIL t1_ch_count: got ch=%0d count=%0d, required ch=0 count=3", dones0[0][33:32], dones0[0][31:0]); errors++; end
        end
        vectors++; if (waited < 95 || waited > 110) begin $display("FAIL t1_timeout_latency: got %0d cycles, required 95..110", waited); errors++; end
        vectors++; if (ack[0][0] !== 1'b1) begin $display("FAIL t1_ack_toggles: got %b, required 1", ack[0][0]); errors++; end
        vectors++; if (busy[0] !== 1'b0) begin $display("FAIL t1_busy_after: got %b, required 0", busy[0]); errors++; end
    endtask

    // T2: links 1 and 2 request together; link1 served first, link2 not ACKed until link1 finishes.
    task automatic test_simultaneous();
        logic [16:0] exp[$];
        int waited;
        bit held = 1'b1;
        do_reset();
        data[0][16 +: 16] = 16'h1111;
        data[0][32 +: 16] = 16'h2222;
        req[0][1] = 1'b1;
        req[0][2] = 1'b1;
        wait_ack(0, 1, 60);
        for (int i = 0; i < 200 && dones0.size() == 0; i++) begin
            @(posedge clk); #1;
            if (ack[0][2] !== 1'b0 && dones0.size() == 0) held = 1'b0;
        end
        vectors++; if (!held) begin $display("FAIL t2_link2_ack_held: got early ack, required 0 until link1 done"); errors++; end
        wait_ack(0, 2, 60);
        wait_done(0, 2, 200, waited);
        repeat (2) @(posedge clk); #1;
        if (HDR) exp.push_back(hdr(2'd1));
        exp.push_back({1'b1, 16'h1111});
        if (HDR) exp.push_back(hdr(2'd2));
        exp.push_back({1'b1, 16'h2222});
        vectors++; if (beats0.size() != exp.size()) begin $display("FAIL t2_beat_count: got %0d, required %0d", beats0.size(), exp.size()); errors++; end
        for (int i = 0; i < exp.size() && i < beats0.size(); i++) begin
            vectors++; if (beats0[i] !== exp[i]) begin $display("FAIL t2_beat%0d: got %h, required %h", i, beats0[i], exp[i]); errors++; end
        end
        vectors++; if (dones0.size() != 2) begin $display("FAIL t2_done_pulses: got %0d, required 2", dones0.size()); errors++; end
        if (dones0.size() == 2) begin
            vectors++; if (dones0[0] !== {2'd1, 32'd1}) begin $display("FAIL t2_first_burst: got %h, required ch=1 count=1", dones0[0]); errors++; end
            vectors++; if (dones0[1] !== {2'd2, 32'd1}) begin $display("FAIL t2_second_burst: got %h, required ch=2 count=1", dones0[1]); errors++; end
        end
        clear_queues();
    endtask

    // T3: ten words on link3 with a 30-cycle output stall in the middle.
    task automatic test_stall();
        logic [16:0] exp[$];
        logic [15:0] held_word;
        int waited;
        bit stable = 1'b1;
        for (int i = 1; i <= 5; i++) send(0, 3, 16'h3000 + 16'(i));
        tready[0] = 1'b0;
        data[0][48 +: 16] = 16'h3006;
        req[0][3] = ~req[0][3];
        held_word = tdata[0];
        repeat (30) begin
            @(posedge clk); #1;
            if (tvalid[0] !== 1'b1 || tdata[0] !== held_word || tlast[0] !== 1'b0 || ack[0][3] === req[0][3]) stable = 1'b0;
        end
        vectors++; if (held_word !== 16'h3004) begin $display("FAIL t3_stalled_word: got %h, required 3004", held_word); errors++; end
        vectors++; if (!stable) begin $display("FAIL t3_stall_stable: got output/ack change during stall, required hold"); errors++; end
        tready[0] = 1'b1;
        wait_ack(0, 3, 60);
        for (int i = 7; i <= 10; i++) send(0, 3, 16'h3000 + 16'(i));
        wait_done(0, 1, 200, waited);
        repeat (2) @(posedge clk); #1;
        if (HDR) exp.push_back(hdr(2'd3));
        for (int i = 1; i <= 10; i++) exp.push_back({(i == 10) ? 1'b1 : 1'b0, 16'h3000 + 16'(i)});
        vectors++; if (beats0.size() != exp.size()) begin $display("FAIL t3_beat_count: got %0d, required %0d", beats0.size(), exp.size()); errors++; end
        for (int i = 0; i < exp.size() && i < beats0.size(); i++) begin
            vectors++; if (beats0[i] !== exp[i]) begin $display("FAIL t3_beat%0d: got %h, required %h", i, beats0[i], exp[i]); errors++; end
        end
        vectors++; if (dones0.size() != 1 || (dones0.size() == 1 && dones0[0] !== {2'd3, 32'd10})) begin
            $display("FAIL t3_burst: got %0d pulses, required one with ch=3 count=10", dones0.size()); errors++;
        end
        clear_queues();
    endtask

    // T4: MAX_BURST=4 build, six words split into bursts of 4 and 2.
    task automatic test_max_burst();
        logic [16:0] exp[$];
        int waited;
        for (int i = 1; i <= 6; i++) send(1, 0, 16'h4000 + 16'(i));
        wait_done(1, 2, 200, waited);
        repeat (2) @(posedge clk); #1;
        if (HDR) exp.push_back(hdr(2'd0));
        for (int i = 1; i <= 4; i++) exp.push_back({(i == 4) ? 1'b1 : 1'b0, 16'h4000 + 16'(i)});
        if (HDR) exp.push_back(hdr(2'd0));
        exp.push_back({1'b0, 16'h4005});
        exp.push_back({1'b1, 16'h4006});
        vectors++; if (beats1.size() != exp.size()) begin $display("FAIL t4_beat_count: got %0d, required %0d", beats1.size(), exp.size()); errors++; end
        for (int i = 0; i < exp.size() && i < beats1.size(); i++) begin
            vectors++; if (beats1[i] !== exp[i]) begin $display("FAIL t4_beat%0d: got %h, required %h", i, beats1[i], exp[i]); errors++; end
        end
        vectors++; if (dones1.size() != 2) begin $display("FAIL t4_done_pulses: got %0d, required 2", dones1.size()); errors++; end
        if (dones1.size() == 2) begin
            vectors++; if (dones1[0] !== {2'd0, 32'd4}) begin $display("FAIL t4_first_count: got %0d, required 4", dones1[0][31:0]); errors++; end
            vectors++; if (dones1[1] !== {2'd0, 32'd2}) begin $display("FAIL t4_second_count: got %0d, required 2", dones1[1][31:0]); errors++; end
        end
        clear_queues();
    endtask

    // T5: reset after two words; held word dropped, later words form a fresh burst.
    task automatic test_reset_mid_burst();
        logic [16:0] exp[$];
        int waited;
        send(1, 0, 16'h5001);
        send(1, 0, 16'h5002);
        repeat (2) @(posedge clk); #1;
        vectors++; if (cnt[1] !== 32'd2) begin $display("FAIL t5_count_before: got %0d, required 2", cnt[1]); errors++; end
        rst_n = 1'b0;
        #1;
        vectors++; if (cnt[1] !== 32'd0) begin $display("FAIL t5_rst_count: got %0d, required 0", cnt[1]); errors++; end
        vectors++; if (busy[1] !== 1'b0) begin $display("FAIL t5_rst_busy: got %b, required 0", busy[1]); errors++; end
        vectors++; if (tvalid[1] !== 1'b0 || tlast[1] !== 1'b0 || tdata[1] !== 16'h0) begin
            $display("FAIL t5_rst_output: got v=%b l=%b d=%h, required 0 0 0000", tvalid[1], tlast[1], tdata[1]); errors++;
        end
        vectors++; if (ack[1] !== 4'b0 || done[1] !== 1'b0 || ch[1] !== 2'd0) begin
            $display("FAIL t5_rst_misc: got ack=%b done=%b ch=%0d, required 0000 0 0", ack[1], done[1], ch[1]); errors++;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(1, 0, 16'h5003);
        send(1, 0, 16'h5004);
        wait_done(1, 1, 100, waited);
        repeat (2) @(posedge clk); #1;
        if (HDR) exp.push_back(hdr(2'd0));
        exp.push_back({1'b0, 16'h5001});
        if (HDR) exp.push_back(hdr(2'd0));
        exp.push_back({1'b0, 16'h5003});
        exp.push_back({1'b1, 16'h5004});
        vectors++; if (beats1.size() != exp.size()) begin $display("FAIL t5_beat_count: got %0d, required %0d", beats1.size(), exp.size()); errors++; end
        for (int i = 0; i < exp.size() && i < beats1.size(); i++) begin
            vectors++; if (beats1[i] !== exp[i]) begin $display("FAIL t5_beat%0d: got %h, required %h", i, beats1[i], exp[i]); errors++; end
        end
        vectors++; if (dones1.size() != 1 || (dones1.size() == 1 && dones1[0] !== {2'd0, 32'd2})) begin
            $display("FAIL t5_burst: got %0d pulses, required one with ch=0 count=2", dones1.size()); errors++;
        end
        clear_queues();
    endtask

`ifdef RX_ARB_HEADER_EN
    // T6: header beat precedes the single data word and is not counted.
    task automatic test_header();
        int waited;
        clear_queues();
        send(0, 2, 16'hBEEF);
        wait_done(0, 1, 200, waited);
        repeat (2) @(posedge clk); #1;
        vectors++; if (beats0.size() != 2) begin $display("FAIL t6_beat_count: got %0d, required 2", beats0.size()); errors++; end
        if (beats0.size() == 2) begin
            vectors++; if (beats0[0] !== {1'b0, 16'hA502}) begin $display("FAIL t6_header: got %h, required 0a502", beats0[0]); errors++; end
            vectors++; if (beats0[1] !== {1'b1, 16'hBEEF}) begin $display("FAIL t6_data: got %h, required 1beef", beats0[1]); errors++; end
        end
        vectors++; if (cnt[0] !== 32'd1) begin $display("FAIL t6_count: got %0d, required 1", cnt[0]); errors++; end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req[0] = '0;    req[1] = '0;
        data[0] = '0;   data[1] = '0;
        tready[0] = 1'b1;
        tready[1] = 1'b1;
        test_reset();
        test_single_burst();
        test_simultaneous();
        test_stall();
        test_max_burst();
        test_reset_mid_burst();
`ifdef RX_ARB_HEADER_EN
        test_header();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
